// File: rtl/vga_timing_pkg.sv
// Shared raster geometry: default 640x480@60 timing and helpers that turn
// visible/porch/sync widths into totals and sync boundaries.
package vga_timing_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int axis_total(input int vis, input int front,
                                    input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  function automatic int sync_start(input int vis, input int front);
    return vis + front;
  endfunction

  // Exclusive end of the sync region
  function automatic int sync_end(input int vis, input int front, input int sync);
    return vis + front + sync;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_strobe.sv
// Pixel-rate enable: divides the system clock by DIV and pulses o_pe on the
// last clk of every pixel period.
module pixel_strobe_gen #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pe
);

  // A 1-bit counter pinned at 0 keeps DIV=1 on the same path (pe always 1)
  localparam int W_CNT = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(DIV - 1);

  logic [W_CNT-1:0] r_div_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == CNT_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_pe = (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel-rate h/v counters with a registered decode of
// visible area, coordinates, sync pulses and pixel/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int clk_mhz          = 50,
  parameter int pixel_mhz        = 25,
  parameter int screen_width     = DEF_SCREEN_W,
  parameter int screen_height    = DEF_SCREEN_H,
  parameter int h_front          = DEF_H_FRONT,
  parameter int h_sync           = DEF_H_SYNC,
  parameter int h_back           = DEF_H_BACK,
  parameter int v_front          = DEF_V_FRONT,
  parameter int v_sync           = DEF_V_SYNC,
  parameter int v_back           = DEF_V_BACK,
  parameter bit hsync_active_low = 1'b1,
  parameter bit vsync_active_low = 1'b1,
  parameter int w_x              = $clog2(screen_width),
  parameter int w_y              = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           pixel_tick,
  output logic           frame_start
);

  localparam int DIV      = clk_mhz / pixel_mhz;
  localparam int H_TOTAL  = axis_total(screen_width, h_front, h_sync, h_back);
  localparam int V_TOTAL  = axis_total(screen_height, v_front, v_sync, v_back);
  localparam int W_H      = $clog2(H_TOTAL);
  localparam int W_V      = $clog2(V_TOTAL);
  localparam int HS_START = sync_start(screen_width, h_front);
  localparam int HS_END   = sync_end(screen_width, h_front, h_sync);
  localparam int VS_START = sync_start(screen_height, v_front);
  localparam int VS_END   = sync_end(screen_height, v_front, v_sync);

  localparam logic [W_H-1:0] H_LAST  = W_H'(H_TOTAL - 1);
  localparam logic [W_V-1:0] V_LAST  = W_V'(V_TOTAL - 1);
  localparam logic           HS_IDLE = hsync_active_low;
  localparam logic           VS_IDLE = vsync_active_low;

  generate
    if (pixel_mhz < 1 || clk_mhz < pixel_mhz || (clk_mhz % pixel_mhz) != 0) begin : g_bad_div
      $error("vga_timing_gen: clk_mhz / pixel_mhz must be an integer >= 1");
    end
  endgenerate

  logic           w_pe;
  logic [W_H-1:0] r_h_cnt;
  logic [W_V-1:0] r_v_cnt;
  logic           r_newpix;
  logic           w_h_vis;
  logic           w_v_vis;
  logic           w_vis;
  logic           w_hs_act;
  logic           w_vs_act;

  logic           r_display_on;
  logic [w_x-1:0] r_x;
  logic [w_y-1:0] r_y;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_pixel_tick;
  logic           r_frame_start;

  pixel_strobe_gen #(
    .DIV (DIV)
  ) u_pixel_strobe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_pe    (w_pe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pe) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign w_h_vis  = int'(r_h_cnt) < screen_width;
  assign w_v_vis  = int'(r_v_cnt) < screen_height;
  assign w_vis    = w_h_vis && w_v_vis;
  assign w_hs_act = (int'(r_h_cnt) >= HS_START) && (int'(r_h_cnt) < HS_END);
  assign w_vs_act = (int'(r_v_cnt) >= VS_START) && (int'(r_v_cnt) < VS_END);

  // newpix marks the first clk after a pe, i.e. the first clk a new pixel is shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_newpix      <= 1'b1;
      r_display_on  <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= HS_IDLE;
      r_vsync       <= VS_IDLE;
      r_pixel_tick  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_newpix      <= w_pe;
      r_display_on  <= w_vis;
      r_x           <= w_vis ? r_h_cnt[w_x-1:0] : '0;
      r_y           <= w_vis ? r_v_cnt[w_y-1:0] : '0;
      r_hsync       <= w_hs_act ^ HS_IDLE;
      r_vsync       <= w_vs_act ^ VS_IDLE;
      r_pixel_tick  <= r_newpix;
      r_frame_start <= r_newpix && (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign display_on  = r_display_on;
  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign pixel_tick  = r_pixel_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three reduced-geometry instances (DIV=2, DIV=1 same
// geometry, and a tiny active-high config) checked every clk against a pixel-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    int w; int h; int hf; int hs; int hb; int vf; int vs; int vb; int div;
    bit hal; bit val;
  } cfg_t;

  typedef struct packed {
    logic de; int x; int y; logic hs; logic vs; logic pt; logic fs;
  } exp_t;

  localparam cfg_t CA = '{w:16, h:8, hf:2, hs:4, hb:2, vf:1, vs:2, vb:1, div:2, hal:1'b1, val:1'b1};
  localparam cfg_t CB = '{w:8,  h:4, hf:1, hs:2, hb:1, vf:1, vs:1, vb:1, div:1, hal:1'b0, val:1'b0};
  localparam cfg_t CC = '{w:16, h:8, hf:2, hs:4, hb:2, vf:1, vs:2, vb:1, div:1, hal:1'b1, val:1'b1};

  logic clk;
  logic rst_n;

  logic       de_a, hs_a, vs_a, pt_a, fs_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic       de_b, hs_b, vs_b, pt_b, fs_b;
  logic [2:0] x_b;
  logic [1:0] y_b;
  logic       de_c, hs_c, vs_c, pt_c, fs_c;
  logic [3:0] x_c;
  logic [2:0] y_c;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int cnt_fs_a, cnt_fs_b, cnt_fs_c, cnt_hs_low_a, cnt_vs_hi_b, cnt_pt_a, cnt_pt_b, cnt_de_a;

  vga_timing_gen #(
    .clk_mhz(50), .pixel_mhz(25), .screen_width(16), .screen_height(8),
    .h_front(2), .h_sync(4), .h_back(2), .v_front(1), .v_sync(2), .v_back(1),
    .hsync_active_low(1'b1), .vsync_active_low(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .display_on(de_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .pixel_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .clk_mhz(25), .pixel_mhz(25), .screen_width(8), .screen_height(4),
    .h_front(1), .h_sync(2), .h_back(1), .v_front(1), .v_sync(1), .v_back(1),
    .hsync_active_low(1'b0), .vsync_active_low(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .display_on(de_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .pixel_tick(pt_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .clk_mhz(25), .pixel_mhz(25), .screen_width(16), .screen_height(8),
    .h_front(2), .h_sync(4), .h_back(2), .v_front(1), .v_sync(2), .v_back(1),
    .hsync_active_low(1'b1), .vsync_active_low(1'b1)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .display_on(de_c), .x(x_c), .y(y_c),
    .hsync(hs_c), .vsync(vs_c), .pixel_tick(pt_c), .frame_start(fs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t k=%0d: got %0d expected %0d", tag, $time, k, obs, exp);
    end
  endtask

  // Expected outputs for the k-th clk edge after reset release
  function automatic exp_t model(input cfg_t c, input int kk);
    exp_t e;
    int htot, vtot, p, h, v;
    logic hs_act, vs_act;
    htot = c.w + c.hf + c.hs + c.hb;
    vtot = c.h + c.vf + c.vs + c.vb;
    p = kk / c.div;
    h = p % htot;
    v = (p / htot) % vtot;
    e.de = (h < c.w) && (v < c.h);
    e.x  = e.de ? h : 0;
    e.y  = e.de ? v : 0;
    hs_act = (h >= c.w + c.hf) && (h < c.w + c.hf + c.hs);
    vs_act = (v >= c.h + c.vf) && (v < c.h + c.vf + c.vs);
    e.hs = c.hal ? !hs_act : hs_act;
    e.vs = c.val ? !vs_act : vs_act;
    e.pt = (kk % c.div) == 0;
    e.fs = e.pt && ((p % (htot * vtot)) == 0);
    return e;
  endfunction

  task automatic cmp(input string who, input exp_t e, input logic de, input int x,
                     input int y, input logic hs, input logic vs, input logic pt, input logic fs);
    check_eq({who, ".display_on"}, 32'(de), 32'(e.de));
    check_eq({who, ".x"}, x, e.x);
    check_eq({who, ".y"}, y, e.y);
    check_eq({who, ".hsync"}, 32'(hs), 32'(e.hs));
    check_eq({who, ".vsync"}, 32'(vs), 32'(e.vs));
    check_eq({who, ".pixel_tick"}, 32'(pt), 32'(e.pt));
    check_eq({who, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".a.display_on"}, 32'(de_a), 0);
    check_eq({tag, ".a.xy"}, {x_a, y_a}, 0);
    check_eq({tag, ".a.syncs"}, {hs_a, vs_a}, 2'b11);
    check_eq({tag, ".a.strobes"}, {pt_a, fs_a}, 0);
    check_eq({tag, ".b.display_on"}, 32'(de_b), 0);
    check_eq({tag, ".b.syncs"}, {hs_b, vs_b}, 2'b00);
    check_eq({tag, ".b.strobes"}, {pt_b, fs_b}, 0);
    check_eq({tag, ".c.all"}, {de_c, x_c, y_c, hs_c, vs_c, pt_c, fs_c}, 13'b0_0000_000_11_00);
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      q_a.push_back(model(CA, k));
      q_b.push_back(model(CB, k));
      q_c.push_back(model(CC, k));
      k++;
      @(negedge clk);
      if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
        check_eq("scoreboard_empty", 1, 0);
      end else begin
        e = q_a.pop_front();
        cmp("a", e, de_a, int'(x_a), int'(y_a), hs_a, vs_a, pt_a, fs_a);
        e = q_b.pop_front();
        cmp("b", e, de_b, int'(x_b), int'(y_b), hs_b, vs_b, pt_b, fs_b);
        e = q_c.pop_front();
        cmp("c", e, de_c, int'(x_c), int'(y_c), hs_c, vs_c, pt_c, fs_c);
      end
      cnt_fs_a     += int'(fs_a);
      cnt_fs_b     += int'(fs_b);
      cnt_fs_c     += int'(fs_c);
      cnt_hs_low_a += int'(!hs_a);
      cnt_vs_hi_b  += int'(vs_b);
      cnt_pt_a     += int'(pt_a);
      cnt_pt_b     += int'(pt_b);
      cnt_de_a     += int'(de_a);
    end
  endtask

  task automatic clear_counts();
    cnt_fs_a = 0; cnt_fs_b = 0; cnt_fs_c = 0; cnt_hs_low_a = 0;
    cnt_vs_hi_b = 0; cnt_pt_a = 0; cnt_pt_b = 0; cnt_de_a = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");

    // Release away from the edge; the next posedge is k=0
    #1 rst_n = 1'b1;
    k = 0;
    run_cycles(1200);

    // Aggregates over 1200 clks: A frame 576 clks, B frame 84, C frame 288
    check_eq("a.frame_start_count", cnt_fs_a, 3);
    check_eq("b.frame_start_count", cnt_fs_b, 15);
    check_eq("c.frame_start_count", cnt_fs_c, 5);
    check_eq("a.hsync_low_clks", cnt_hs_low_a, 200);
    check_eq("b.vsync_high_clks", cnt_vs_hi_b, 168);
    check_eq("a.pixel_tick_count", cnt_pt_a, 600);
    check_eq("b.pixel_tick_count", cnt_pt_b, 1200);
    check_eq("a.display_on_clks", cnt_de_a, 544);

    // Land mid-frame in the visible area, then assert reset between edges
    run_cycles(101);
    check_eq("a.pre_reset_visible", 32'(de_a), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("held_reset");
    #1 rst_n = 1'b1;
    k = 0;
    clear_counts();
    run_cycles(1);
    check_eq("restart.a.frame_start", 32'(fs_a), 1);
    check_eq("restart.a.xy", {x_a, y_a}, 0);
    check_eq("restart.b.frame_start", 32'(fs_b), 1);
    run_cycles(700);
    check_eq("restart.a.frame_start_count", cnt_fs_a, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
